// File: rtl/apb_pkg.sv
// Shared types for the APB requester: FSM state encoding, protection width
// and the default-width request bundle used by SoC glue around the requester.
package apb_pkg;

    localparam int APB_PROT_W = 3;
    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;
    localparam int APB_STRB_W = APB_DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_req_state_t;

    // One front-end request at the default bus widths.
    typedef struct packed {
        logic                  write;
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0] wdata;
        logic [APB_STRB_W-1:0] strb;
        logic [APB_PROT_W-1:0] prot;
    } apb_req_t;

endpackage

// File: rtl/apb_wait_timer.sv
// ACCESS wait-state counter: cleared by load_i, advanced by inc_i, and
// expired_o flags the cycle on which one more wait would reach LIMIT.
module apb_wait_timer #(
    parameter int unsigned LIMIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic inc_i,
    output logic expired_o
);

    localparam int unsigned CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Clear on load, otherwise count waits and saturate at the limit.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = '0;
        end else if (inc_i && (count_q < CNT_W'(LIMIT))) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/apb_requester.sv
// APB4 requester: accepts one valid/ready request at a time, runs it as an
// APB SETUP/ACCESS transfer with PREADY wait states and returns a one-cycle
// response pulse carrying read data and PSLVERR.
// Optional feature: define APB_REQUESTER_TIMEOUT_EN to abort an ACCESS phase
// that waits TIMEOUT_CYCLES cycles without PREADY (reported as an error).
module apb_requester
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    // request front end
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_strb,
    input  logic [APB_PROT_W-1:0]   req_prot,
    // response
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_error,
    // APB
    output logic                    PSEL,
    output logic                    PENABLE,
    output logic                    PWRITE,
    output logic [ADDR_WIDTH-1:0]   PADDR,
    output logic [DATA_WIDTH-1:0]   PWDATA,
    output logic [DATA_WIDTH/8-1:0] PSTRB,
    output logic [APB_PROT_W-1:0]   PPROT,
    input  logic [DATA_WIDTH-1:0]   PRDATA,
    input  logic                    PREADY,
    input  logic                    PSLVERR
);

    localparam int STRB_W = DATA_WIDTH / 8;

    // Latched request at this instance's bus widths.
    typedef struct packed {
        logic                  write;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic [STRB_W-1:0]     strb;
        logic [APB_PROT_W-1:0] prot;
    } req_t;

    apb_req_state_t        state_q;
    apb_req_state_t        state_d;
    req_t                  req_q;
    req_t                  req_d;
    logic                  rsp_valid_q;
    logic                  rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_d;
    logic                  rsp_error_q;
    logic                  rsp_error_d;
    logic                  timeout;

`ifdef APB_REQUESTER_TIMEOUT_EN
    logic tmr_load;
    logic tmr_inc;
    logic tmr_expired;

    assign tmr_load = (state_q == SETUP);
    assign tmr_inc  = (state_q == ACCESS) && !PREADY;

    apb_wait_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk       (PCLK),
        .rst_n     (PRESETn),
        .load_i    (tmr_load),
        .inc_i     (tmr_inc),
        .expired_o (tmr_expired)
    );

    // Abort only when this wait would reach the limit; PREADY still wins.
    assign timeout = tmr_inc && tmr_expired;
`else
    // Without the timer the ACCESS phase waits for PREADY indefinitely.
    logic [31:0] unused_timeout_cycles;
    assign unused_timeout_cycles = 32'(TIMEOUT_CYCLES);
    assign timeout               = 1'b0;
`endif

    // Next-state, request capture and response generation.
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_error_d = rsp_error_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    req_d.write = req_write;
                    req_d.addr  = req_addr;
                    req_d.wdata = req_wdata;
                    // Reads never present byte strobes on the bus.
                    req_d.strb  = req_write ? req_strb : '0;
                    req_d.prot  = req_prot;
                    state_d     = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (PREADY) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_error_d = PSLVERR;
                    rsp_rdata_d = (!req_q.write && !PSLVERR) ? PRDATA : '0;
                end else if (timeout) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_error_d = 1'b1;
                    rsp_rdata_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, request and response registers.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= IDLE;
            req_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_error_q <= rsp_error_d;
        end
    end

    // PSEL/PENABLE decode straight from the state register so they fall
    // together with the asynchronous reset.
    assign req_ready = (state_q == IDLE);
    assign PSEL      = (state_q == SETUP) || (state_q == ACCESS);
    assign PENABLE   = (state_q == ACCESS);
    assign PWRITE    = req_q.write;
    assign PADDR     = req_q.addr;
    assign PWDATA    = req_q.wdata;
    assign PSTRB     = req_q.strb;
    assign PPROT     = req_q.prot;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_error = rsp_error_q;

endmodule

// File: tb/tb_apb_requester.sv
// Directed bench for apb_requester: a driver task issues requests and plays
// the APB completer, pushing each expected response into a scoreboard queue;
// an independent monitor pops and compares on every rsp_valid pulse.
module tb_apb_requester;

    localparam int TMO = 4;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_strb;
    logic [2:0]  req_prot;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic [2:0]  PPROT;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    always #5 PCLK = ~PCLK;

    apb_requester #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_strb  (req_strb),
        .req_prot  (req_prot),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_error (rsp_error),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PSTRB     (PSTRB),
        .PPROT     (PPROT),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
        string       name;
    } exp_t;

    exp_t sb[$];

    always @(posedge PCLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Monitor: every response pulse must match the oldest outstanding expectation.
    always @(negedge PCLK) begin
        if (PRESETn === 1'b1 && rsp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL rsp_unexpected: got rsp_valid=1 at cycle %0d required none", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_rdata"}, 64'(rsp_rdata), 64'(e.rdata));
                check({e.name, "_error"}, 64'(rsp_error), 64'(e.err));
                check({e.name, "_cycle"}, 64'(cyc), 64'(e.cyc));
                $display("[TB] rsp %s rdata=%h err=%b cycle=%0d", e.name, rsp_rdata, rsp_error, cyc);
            end
        end
    end

    // Issue one request and act as the completer. Starts and ends at a negedge.
    task automatic xfer(input string name, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb, input logic [2:0] prot,
                        input int waits, input logic [31:0] rdata, input logic err,
                        input bit keep, input bit noise, input int rst_at,
                        output int setup_cyc);
        int   acc_n;
        bit   to;
        int   k;
        exp_t e;
        acc_n = waits + 1;
        to    = 1'b0;
`ifdef APB_REQUESTER_TIMEOUT_EN
        if (waits >= TMO) begin
            acc_n = TMO;
            to    = 1'b1;
        end
`endif
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_strb  = strb;
        req_prot  = prot;
        k = 0;
        while (req_ready !== 1'b1 && k < 20) begin
            @(negedge PCLK);
            k++;
        end
        check({name, "_req_ready"}, 64'(req_ready), 64'd1);
        @(posedge PCLK);
        @(negedge PCLK);
        setup_cyc = cyc;
        if (!keep) req_valid = 1'b0;
        e.rdata = (to || wr || err) ? 32'h0 : rdata;
        e.err   = to ? 1'b1 : err;
        e.cyc   = cyc + 1 + acc_n;
        e.name  = name;
        sb.push_back(e);
        $display("[TB] req %s wr=%b addr=%h wdata=%h strb=%h waits=%0d", name, wr, addr, wdata, strb, waits);
        // SETUP phase
        check({name, "_setup_sel_en"}, 64'({PSEL, PENABLE}), 64'(2'b10));
        check({name, "_setup_ready"}, 64'(req_ready), 64'd0);
        check({name, "_pwrite"}, 64'(PWRITE), 64'(wr));
        check({name, "_paddr"}, 64'(PADDR), 64'(addr));
        check({name, "_pstrb"}, 64'(PSTRB), 64'(wr ? strb : 4'h0));
        check({name, "_pprot"}, 64'(PPROT), 64'(prot));
        if (wr) check({name, "_pwdata"}, 64'(PWDATA), 64'(wdata));
        if (noise) begin
            PREADY  = 1'b1;
            PRDATA  = 32'hFFFF_FFFF;
            PSLVERR = 1'b1;
        end
        // ACCESS phase
        for (int i = 1; i <= acc_n; i++) begin
            @(negedge PCLK);
            check({name, "_access_sel_en"}, 64'({PSEL, PENABLE}), 64'(2'b11));
            check({name, "_access_paddr"}, 64'(PADDR), 64'(addr));
            check({name, "_access_pstrb"}, 64'(PSTRB), 64'(wr ? strb : 4'h0));
            if (i == rst_at) begin
                PRESETn = 1'b0;
                #1;
                check({name, "_rst_sel_en"}, 64'({PSEL, PENABLE}), 64'd0);
                e = sb.pop_back();
                PREADY  = 1'b0;
                PSLVERR = 1'b0;
                @(negedge PCLK);
                check({name, "_rst_rsp_valid"}, 64'(rsp_valid), 64'd0);
                check({name, "_rst_paddr"}, 64'(PADDR), 64'd0);
                PRESETn = 1'b1;
                @(negedge PCLK);
                check({name, "_post_rst_ready"}, 64'(req_ready), 64'd1);
                check({name, "_post_rst_psel"}, 64'(PSEL), 64'd0);
                return;
            end
            PREADY  = !to && (i == acc_n);
            PRDATA  = rdata;
            PSLVERR = err;
        end
        @(negedge PCLK);
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        PRDATA  = 32'h0;
        check({name, "_idle_psel"}, 64'(PSEL), 64'd0);
    endtask

    initial begin
        int c0, c1, c2, c3, cx;
        PRESETn   = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        req_strb  = 4'h0;
        req_prot  = 3'h0;
        PRDATA    = 32'h0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;
        repeat (3) @(negedge PCLK);
        check("reset_req_ready", 64'(req_ready), 64'd1);
        check("reset_sel_en", 64'({PSEL, PENABLE}), 64'd0);
        check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset_paddr", 64'(PADDR), 64'd0);
        check("reset_pstrb_pwrite", 64'({PSTRB, PWRITE}), 64'd0);
        check("reset_pwdata", 64'(PWDATA), 64'd0);
        PRESETn = 1'b1;
        @(negedge PCLK);

        xfer("t1_write", 1'b1, 32'h8000_0004, 32'hDEAD_BEEF, 4'hF, 3'd0, 0, 32'h0, 1'b0, 1'b0, 1'b0, 0, cx);
        xfer("t2_read_wait", 1'b0, 32'h8000_0008, 32'h0BAD_0BAD, 4'hF, 3'd2, 3, 32'h1234_5678, 1'b0, 1'b0, 1'b1, 0, cx);
        xfer("t3_read_err", 1'b0, 32'h8000_000C, 32'h0, 4'h0, 3'd1, 0, 32'hAAAA_5555, 1'b1, 1'b0, 1'b0, 0, cx);
        xfer("t3_write_err", 1'b1, 32'h8000_0010, 32'h0000_00FF, 4'h3, 3'd7, 1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 0, cx);

        xfer("t4_b2b_0", 1'b1, 32'h0000_0010, 32'h1111_1111, 4'h1, 3'd0, 0, 32'h0, 1'b0, 1'b1, 1'b0, 0, c0);
        xfer("t4_b2b_1", 1'b0, 32'h0000_0014, 32'h0, 4'h0, 3'd0, 0, 32'hCAFE_F00D, 1'b0, 1'b1, 1'b0, 0, c1);
        xfer("t4_b2b_2", 1'b1, 32'h0000_0018, 32'h2222_3333, 4'hC, 3'd0, 0, 32'h0, 1'b0, 1'b1, 1'b0, 0, c2);
        xfer("t4_b2b_3", 1'b0, 32'h0000_001C, 32'h0, 4'h0, 3'd0, 0, 32'h0BAD_C0DE, 1'b0, 1'b0, 1'b0, 0, c3);
        check("t4_period_01", 64'(c1 - c0), 64'd3);
        check("t4_period_12", 64'(c2 - c1), 64'd3);
        check("t4_period_23", 64'(c3 - c2), 64'd3);

        xfer("t5_stall", 1'b0, 32'h8000_0020, 32'h0, 4'h0, 3'd0, 100, 32'h5A5A_0001, 1'b0, 1'b0, 1'b0, 0, cx);

        xfer("t6_reset", 1'b1, 32'h8000_0024, 32'h1357_9BDF, 4'hF, 3'd0, 5, 32'h0, 1'b0, 1'b0, 1'b0, 2, cx);
        xfer("t6_after", 1'b0, 32'h8000_0028, 32'h0, 4'h0, 3'd0, 1, 32'h2468_ACE0, 1'b0, 1'b0, 1'b0, 0, cx);

        repeat (5) @(negedge PCLK);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Bound the whole run so a stuck handshake still reaches a verdict.
    initial begin
        #50000;
        tests_run++;
        tests_failed++;
        $display("FAIL watchdog: got no completion by %0t required finish", $time);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $fatal(1, "watchdog expired");
    end

endmodule
